// File: rtl/id_stage_pipe_if.sv
// Handshake and bus bundle for the decode stage: IF-side request, writeback port,
// and the registered ID/EX payload presented to execute.
interface id_stage_pipe_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc_in;
    logic            flush;
    logic            wb_we;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_ready;
    logic            out_valid;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic [XLEN-1:0] pc_out;
    logic            branch;
    logic            memread;
    logic            memtoreg;
    logic            memwrite;
    logic            alusrc;
    logic            regwrite;
    logic [1:0]      aluop;
    logic            hazard_stall;

    modport slave (
        input  in_valid, instruction, pc_in, flush, wb_we, wb_rd, wb_data, ex_ready,
        output in_ready, out_valid, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3,
        funct7b5, pc_out, branch, memread, memtoreg, memwrite, alusrc, regwrite,
        aluop, hazard_stall
    );

    modport master (
        output in_valid, instruction, pc_in, flush, wb_we, wb_rd, wb_data, ex_ready,
        input  in_ready, out_valid, rs1_data, rs2_data, imm, rs1, rs2, rd, funct3,
        funct7b5, pc_out, branch, memread, memtoreg, memwrite, alusrc, regwrite,
        aluop, hazard_stall
    );
endinterface

// File: rtl/id_stage_pipe.sv
// RV32I decode stage with register file, load-use stall and ID/EX register.
// Define RF_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module id_stage_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    id_stage_pipe_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            branch;
        logic            memread;
        logic            memtoreg;
        logic            memwrite;
        logic            alusrc;
        logic            regwrite;
        logic [1:0]      aluop;
    } idex_t;

    idex_t           dec;
    idex_t           idex_q;
    logic            valid_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] rf [NREG];
    logic            hazard;
    logic            ready;

    logic [31:0] ins;
    logic [AW-1:0] f_rs1, f_rs2, f_rd;
    assign ins   = bus.instruction;
    assign f_rs1 = ins[15 +: AW];
    assign f_rs2 = ins[20 +: AW];
    assign f_rd  = ins[7 +: AW];

    always_comb begin
        dec          = '0;
        dec.pc       = bus.pc_in;
        dec.funct3   = ins[14:12];
        dec.funct7b5 = ins[30];
        unique case (ins[6:0])
            OP_LOAD: begin
                dec.imm = XLEN'($signed(ins[31:20]));
                dec.rs1 = f_rs1; dec.rd = f_rd;
                dec.memread = 1'b1; dec.memtoreg = 1'b1;
                dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b00;
            end
            OP_IMM: begin
                dec.imm = XLEN'($signed(ins[31:20]));
                dec.rs1 = f_rs1; dec.rd = f_rd;
                dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b11;
            end
            OP_JALR: begin
                dec.imm = XLEN'($signed(ins[31:20]));
                dec.rs1 = f_rs1; dec.rd = f_rd;
                dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b00;
            end
            OP_STORE: begin
                dec.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
                dec.rs1 = f_rs1; dec.rs2 = f_rs2;
                dec.memwrite = 1'b1; dec.alusrc = 1'b1; dec.aluop = 2'b00;
            end
            OP_BRANCH: begin
                dec.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                dec.rs1 = f_rs1; dec.rs2 = f_rs2;
                dec.branch = 1'b1; dec.aluop = 2'b01;
            end
            OP_LUI, OP_AUIPC: begin
                dec.imm = XLEN'($signed({ins[31:12], 12'b0}));
                dec.rd = f_rd;
                dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b11;
            end
            OP_JAL: begin
                dec.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                dec.rd = f_rd;
                dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b11;
            end
            OP_REG: begin
                dec.rs1 = f_rs1; dec.rs2 = f_rs2; dec.rd = f_rd;
                dec.regwrite = 1'b1; dec.aluop = 2'b10;
            end
            default: ;
        endcase
    end

    // Reads use the masked addresses so unused fields never see bypass data.
    always_comb begin
        rdata1 = (dec.rs1 == '0) ? '0 : rf[dec.rs1];
        rdata2 = (dec.rs2 == '0) ? '0 : rf[dec.rs2];
`ifdef RF_BYPASS_EN
        if (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == dec.rs1) rdata1 = bus.wb_data;
        if (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == dec.rs2) rdata2 = bus.wb_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (bus.wb_we && bus.wb_rd != '0) begin
            rf[bus.wb_rd] <= bus.wb_data;
        end
    end

    assign hazard = bus.in_valid & valid_q & idex_q.memread & (idex_q.rd != '0) &
                    ((idex_q.rd == dec.rs1) | (idex_q.rd == dec.rs2));
    assign ready  = (~valid_q | bus.ex_ready) & ~hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            idex_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (bus.in_valid && ready) begin
            valid_q    <= 1'b1;
            idex_q     <= dec;
            rs1_data_q <= rdata1;
            rs2_data_q <= rdata2;
        end else if (bus.ex_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready     = ready;
    assign bus.hazard_stall = hazard;
    assign bus.out_valid    = valid_q;
    assign bus.rs1_data     = rs1_data_q;
    assign bus.rs2_data     = rs2_data_q;
    assign bus.imm          = idex_q.imm;
    assign bus.pc_out       = idex_q.pc;
    assign bus.rs1          = idex_q.rs1;
    assign bus.rs2          = idex_q.rs2;
    assign bus.rd           = idex_q.rd;
    assign bus.funct3       = idex_q.funct3;
    assign bus.funct7b5     = idex_q.funct7b5;
    assign bus.branch       = idex_q.branch;
    assign bus.memread      = idex_q.memread;
    assign bus.memtoreg     = idex_q.memtoreg;
    assign bus.memwrite     = idex_q.memwrite;
    assign bus.alusrc       = idex_q.alusrc;
    assign bus.regwrite     = idex_q.regwrite;
    assign bus.aluop        = idex_q.aluop;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode fields, register file, load-use stall,
// backpressure hold, flush and writeback forwarding.
module tb_id_stage_pipe;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(32), .NREG(32)) bus ();
    id_stage_pipe #(.XLEN(32), .NREG(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    localparam logic [31:0] I_ADDI  = 32'hFFB0_0093; // addi x1,x0,-5
    localparam logic [31:0] I_LW    = 32'h0001_2283; // lw   x5,0(x2)
    localparam logic [31:0] I_ADD6  = 32'h0012_8333; // add  x6,x5,x1
    localparam logic [31:0] I_SW    = 32'h0011_2423; // sw   x1,8(x2)
    localparam logic [31:0] I_BEQ   = 32'hFE20_8EE3; // beq  x1,x2,-4
    localparam logic [31:0] I_LUI   = 32'h1234_5537; // lui  x10,0x12345
    localparam logic [31:0] I_JAL   = 32'h0080_00EF; // jal  x1,+8
    localparam logic [31:0] I_ADD8  = 32'h0003_8433; // add  x8,x7,x0
    localparam logic [31:0] I_RD7   = 32'h0003_8033; // add  x0,x7,x0
    localparam logic [31:0] I_RD12  = 32'h0020_8033; // add  x0,x1,x2
    localparam logic [31:0] I_BAD   = 32'h0000_007F;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        bus.wb_we = 1'b1; bus.wb_rd = r; bus.wb_data = d;
        step();
        bus.wb_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        bus.instruction = ins; bus.pc_in = pc; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] old_x7;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.instruction = '0; bus.pc_in = '0; bus.flush = 1'b0;
        bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0; bus.ex_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_imm", bus.imm, 0);
        chk("rst_rd", bus.rd, 0);
        chk("rst_rs1_data", bus.rs1_data, 0);
        chk("rst_ctrl", {bus.regwrite, bus.memread, bus.aluop}, 0);
        chk("rst_pc", bus.pc_out, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // every register reads 0 after reset
        v = 0;
        for (int i = 1; i < 32; i++) begin
            issue({7'b0, 5'(i), 5'(i), 3'b0, 5'b0, 7'b0110011}, 32'h0);
            v = v | bus.rs1_data | bus.rs2_data;
        end
        chk("rf_reset_or", v, 0);

        issue(I_ADDI, 32'h100);
        chk("addi_valid", bus.out_valid, 1);
        chk("addi_imm", bus.imm, 32'hFFFF_FFFB);
        chk("addi_rd", bus.rd, 1);
        chk("addi_rs2", bus.rs2, 0);
        chk("addi_ctrl", {bus.alusrc, bus.regwrite, bus.aluop, bus.memread}, 5'b11110);
        chk("addi_pc", bus.pc_out, 32'h100);
        step();
        chk("drain_valid", bus.out_valid, 0);

        wb(5'd1, 32'h11);
        wb(5'd2, 32'h1000);
        wb(5'd7, 32'h77);
        wb(5'd0, 32'h1234);
        old_x7 = 32'h77;
        issue(I_RD12, 32'h104);
        chk("rf_x1", bus.rs1_data, 32'h11);
        chk("rf_x2", bus.rs2_data, 32'h1000);
        issue(32'h0000_0033, 32'h108); // add x0,x0,x0
        chk("rf_x0", bus.rs1_data, 0);

        // same-cycle writeback while decoding a reader of x7
        bus.wb_we = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'hDEAD_BEEF;
        issue(I_ADD8, 32'h10C);
        bus.wb_we = 1'b0;
`ifdef RF_BYPASS_EN
        chk("fwd_x7", bus.rs1_data, 32'hDEAD_BEEF);
`else
        chk("fwd_x7", bus.rs1_data, old_x7);
`endif
        chk("fwd_rd", bus.rd, 8);
        issue(I_RD7, 32'h110);
        chk("x7_written", bus.rs1_data, 32'hDEAD_BEEF);

        // load-use stall
        issue(I_LW, 32'h200);
        chk("lw_ctrl", {bus.memread, bus.memtoreg, bus.aluop}, 4'b1100);
        chk("lw_rs1_data", bus.rs1_data, 32'h1000);
        bus.instruction = I_ADD6; bus.pc_in = 32'h204; bus.in_valid = 1'b1;
        #1;
        chk("lu_hazard", bus.hazard_stall, 1);
        chk("lu_in_ready", bus.in_ready, 0);
        step();
        chk("lu_bubble", bus.out_valid, 0);
        chk("lu_ready_after", {bus.hazard_stall, bus.in_ready}, 2'b01);
        step();
        chk("lu_add_valid", bus.out_valid, 1);
        chk("lu_add_regs", {bus.rd, bus.rs1, bus.rs2}, {5'd6, 5'd5, 5'd1});
        chk("lu_add_aluop", bus.aluop, 2'b10);
        chk("lu_add_rs2_data", bus.rs2_data, 32'h11);

        // backpressure hold
        bus.ex_ready = 1'b0; bus.instruction = I_SW; bus.pc_in = 32'h208;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_in_ready", bus.in_ready, 0);
            step();
            chk("hold_state", {bus.out_valid, bus.rd, bus.aluop, bus.memwrite}, {1'b1, 5'd6, 2'b10, 1'b0});
            chk("hold_pc", bus.pc_out, 32'h204);
        end
        bus.ex_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("sw_imm", bus.imm, 8);
        chk("sw_regs", {bus.rd, bus.rs1, bus.rs2}, {5'd0, 5'd2, 5'd1});
        chk("sw_ctrl", {bus.memwrite, bus.alusrc, bus.regwrite, bus.aluop}, 5'b11000);
        chk("sw_rs2_data", bus.rs2_data, 32'h11);

        // flush with an incoming instruction
        bus.ex_ready = 1'b0; bus.flush = 1'b1;
        issue(I_BEQ, 32'h20C);
        bus.flush = 1'b0; bus.ex_ready = 1'b1;
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_kept", {bus.memwrite, bus.branch}, 2'b10);
        chk("flush_imm", bus.imm, 8);

        // flush during a load-use stall
        issue(I_LW, 32'h300);
        bus.instruction = I_ADD6; bus.pc_in = 32'h304; bus.in_valid = 1'b1; bus.flush = 1'b1;
        #1;
        chk("fs_hazard", bus.hazard_stall, 1);
        step();
        bus.flush = 1'b0;
        chk("fs_valid", bus.out_valid, 0);
        chk("fs_ready", {bus.hazard_stall, bus.in_ready}, 2'b01);
        step();
        bus.in_valid = 1'b0;
        chk("fs_add", {bus.out_valid, bus.rd}, {1'b1, 5'd6});
        chk("fs_pc", bus.pc_out, 32'h304);

        // immediate formats and masking
        issue(I_BEQ, 32'h400);
        chk("beq_imm", bus.imm, 32'hFFFF_FFFC);
        chk("beq_ctrl", {bus.branch, bus.aluop, bus.regwrite, bus.rd}, {1'b1, 2'b01, 1'b0, 5'd0});
        issue(I_LUI, 32'h404);
        chk("lui_imm", bus.imm, 32'h1234_5000);
        chk("lui_regs", {bus.rd, bus.rs1, bus.rs2}, {5'd10, 5'd0, 5'd0});
        issue(I_JAL, 32'h408);
        chk("jal_imm", bus.imm, 8);
        chk("jal_regs", {bus.rd, bus.rs1, bus.rs2, bus.aluop}, {5'd1, 5'd0, 5'd0, 2'b11});
        issue(I_BAD, 32'h40C);
        chk("bad_valid", bus.out_valid, 1);
        chk("bad_ctrl", {bus.imm, bus.branch, bus.memread, bus.memtoreg, bus.memwrite,
                         bus.alusrc, bus.regwrite, bus.aluop}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
